// File: rtl/adc_apb_pkg.sv
// Shared types and constants for the ADC register-file APB initiator.
package adc_apb_pkg;

    // Initiator sequencing: wait for a command, run one bus access, then
    // hold the bus idle while the beat's response is handed off.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        POST   = 2'd2
    } state_t;

    localparam int ADDR_W_DEFAULT  = 21;
    localparam int DATA_W_DEFAULT  = 16;
    localparam int LEN_W_DEFAULT   = 7;
    localparam int TIMEOUT_DEFAULT = 255;

    // Read data reported when a beat is aborted for lack of pready.
    localparam logic [15:0] ERR_DATA = 16'hffff;

    // Fixed-address sample FIFO port of the ADC register file.
    localparam logic [20:0] SAMPLE_PORT_ADDR = 21'h7fff;

endpackage : adc_apb_pkg

// File: rtl/adc_apb_master.sv
// APB-style initiator for the ADC register file. Accepts one command at a
// time, expands it into (cmd_len+1) bus beats at a fixed or incrementing
// address, and returns per-beat read data (or one completion for writes)
// on a valid/ready response stream. Beats that never see pready are
// aborted after TIMEOUT cycles and the rest of the command is dropped.
module adc_apb_master
    import adc_apb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int LEN_W   = LEN_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_incr,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              busy,
    output logic              psel,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t              state;
    logic [ADDR_W-1:0]   base_addr;
    logic                incr_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    beat;
    logic [TO_W-1:0]     tcnt;
    logic                accept;
    logic                last_beat;
    logic [LEN_W-1:0]    next_beat;
    logic [ADDR_W-1:0]   next_addr;

    // Command port is open only when idle and out of reset, so cmd_rdy is
    // already low while rstn is asserted and high as soon as it releases.
    assign cmd_rdy   = rstn && (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_vld && cmd_rdy;
    assign last_beat = (beat == len_q);
    assign next_beat = beat + 1'b1;
    // Incrementing bursts wrap naturally at 2^ADDR_W.
    assign next_addr = incr_q ? (base_addr + ADDR_W'(next_beat)) : base_addr;

    // Main sequencer: command capture, bus access with timeout, and the
    // response hand-off that also enforces an idle bus cycle between beats.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            base_addr <= '0;
            incr_q    <= 1'b0;
            len_q     <= '0;
            beat      <= '0;
            tcnt      <= '0;
            psel      <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_vld   <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        base_addr <= cmd_addr;
                        incr_q    <= cmd_incr;
                        len_q     <= cmd_len;
                        beat      <= '0;
                        tcnt      <= '0;
                        psel      <= 1'b1;
                        paddr     <= cmd_addr;
                        pwrite    <= cmd_write;
                        pwdata    <= cmd_wdata;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (pready) begin
                        psel  <= 1'b0;
                        state <= POST;
                        if (!pwrite || last_beat) begin
                            rsp_vld  <= 1'b1;
                            rsp_data <= pwrite ? '0 : prdata;
                            rsp_last <= last_beat;
                            rsp_err  <= 1'b0;
                        end
                    end else if (tcnt == TO_W'(TIMEOUT - 1)) begin
                        psel     <= 1'b0;
                        state    <= POST;
                        rsp_vld  <= 1'b1;
                        rsp_data <= DATA_W'(ERR_DATA);
                        rsp_last <= 1'b1;
                        rsp_err  <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                POST: begin
                    if (!rsp_vld || rsp_rdy) begin
                        rsp_vld <= 1'b0;
                        if (rsp_vld && rsp_last) begin
                            state <= IDLE;
                        end else begin
                            beat  <= next_beat;
                            tcnt  <= '0;
                            paddr <= next_addr;
                            psel  <= 1'b1;
                            state <= ACCESS;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : adc_apb_master

// File: tb/tb_adc_apb_master.sv
// Directed self-checking bench for adc_apb_master with a small APB slave
// model (same-cycle, one-wait-state or never-ready) and a response logger.
module tb_adc_apb_master;
    import adc_apb_pkg::*;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        rstn;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic        cmd_write;
    logic [20:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic [6:0]  cmd_len;
    logic        cmd_incr;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [15:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    logic        busy;
    logic        psel;
    logic [20:0] paddr;
    logic        pwrite;
    logic [15:0] pwdata;
    logic [15:0] prdata;
    logic        pready;

    int          testCount = 0;
    int          failCount = 0;
    int          slaveMode = 0;
    logic [15:0] dataBase  = '0;
    int          xferStart = 0;
    int          xferCount = 0;
    int          runLen    = 0;
    int          lastRun   = 0;
    int          pselRises = 0;
    logic        pselPrev  = 1'b0;
    rsp_t        rspQ[$];
    logic [20:0] addrQ[$];

    adc_apb_master dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_vld   (cmd_vld),
        .cmd_rdy   (cmd_rdy),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_len   (cmd_len),
        .cmd_incr  (cmd_incr),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .psel      (psel),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: mode 0 ready in first psel cycle, mode 1 one wait state,
    // mode 2 never ready. Read data counts up from dataBase per transfer.
    assign pready = psel && ((slaveMode == 0) || ((slaveMode == 1) && (runLen != 0)));
    assign prdata = dataBase + 16'(xferCount - xferStart);

    // Bus monitor: psel run lengths, rising edges and completed addresses.
    always @(posedge clk) begin
        pselPrev <= psel;
        if (psel && !pselPrev) pselRises <= pselRises + 1;
        if (psel) begin
            runLen <= runLen + 1;
        end else if (runLen != 0) begin
            lastRun <= runLen;
            runLen  <= 0;
        end
        if (psel && pready) begin
            addrQ.push_back(paddr);
            xferCount <= xferCount + 1;
        end
    end

    // Response logger: one entry per cycle that ends in a handshake.
    always @(negedge clk) begin
        if (rstn && rsp_vld && rsp_rdy) rspQ.push_back('{data: rsp_data, last: rsp_last, err: rsp_err});
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=hang expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one command; returns just after the accepting edge (psel cycle).
    task automatic applyStimulus(input logic w, input logic [20:0] a, input logic [15:0] d,
                                 input logic [6:0] l, input logic inc);
        int n;
        @(posedge clk);
        #1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_len   = l;
        cmd_incr  = inc;
        cmd_vld   = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_rdy && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("cmd_accept", {31'd0, cmd_rdy}, 32'd1);
        @(posedge clk);
        #1;
        cmd_vld = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int s;
        int a;
        int errs;
        int lastErrs;
        rsp_t r0;

        rstn      = 1'b0;
        cmd_vld   = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_len   = '0;
        cmd_incr  = 1'b0;
        rsp_rdy   = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_psel", {31'd0, psel}, 32'd0);
        checkOutput("rst_paddr", {11'd0, paddr}, 32'd0);
        checkOutput("rst_pwrite", {31'd0, pwrite}, 32'd0);
        checkOutput("rst_pwdata", {16'd0, pwdata}, 32'd0);
        checkOutput("rst_rsp_vld", {31'd0, rsp_vld}, 32'd0);
        checkOutput("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        checkOutput("rst_rsp_last_err", {30'd0, rsp_last, rsp_err}, 32'd0);
        checkOutput("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        #1;
        checkOutput("rel_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);

        // Single write, slave ready in the first psel cycle
        slaveMode = 0;
        s = rspQ.size();
        applyStimulus(1'b1, 21'h0, 16'h0005, 7'd0, 1'b0);
        @(negedge clk);
        checkOutput("wr_psel", {31'd0, psel}, 32'd1);
        checkOutput("wr_pwrite", {31'd0, pwrite}, 32'd1);
        checkOutput("wr_pwdata", {16'd0, pwdata}, 32'h5);
        checkOutput("wr_paddr", {11'd0, paddr}, 32'h0);
        @(negedge clk);
        checkOutput("wr_psel_drop", {31'd0, psel}, 32'd0);
        checkOutput("wr_rsp_vld", {31'd0, rsp_vld}, 32'd1);
        checkOutput("wr_rsp", {14'd0, rsp_data, rsp_last, rsp_err}, {14'd0, 16'h0, 1'b1, 1'b0});
        @(negedge clk);
        checkOutput("wr_rsp_done", {30'd0, rsp_vld, psel}, 32'd0);
        checkOutput("wr_rsp_count", rspQ.size() - s, 32'd1);

        // Single read, response at T+2
        dataBase  = 16'h0001;
        xferStart = xferCount;
        applyStimulus(1'b0, 21'h3, 16'h0, 7'd0, 1'b0);
        @(negedge clk);
        checkOutput("rd_t1_psel_vld", {30'd0, psel, rsp_vld}, 32'd2);
        checkOutput("rd_paddr", {11'd0, paddr}, 32'h3);
        @(negedge clk);
        checkOutput("rd_t2_psel_vld", {30'd0, psel, rsp_vld}, 32'd1);
        checkOutput("rd_rsp", {14'd0, rsp_data, rsp_last, rsp_err}, {14'd0, 16'h0001, 1'b1, 1'b0});
        waitIdle("rd_idle", 20);

        // Fixed-address burst of 96 reads from the sample port, one wait state
        slaveMode = 1;
        dataBase  = 16'h0000;
        xferStart = xferCount;
        s = rspQ.size();
        a = addrQ.size();
        pselRises = 0;
        applyStimulus(1'b0, SAMPLE_PORT_ADDR, 16'h0, 7'd95, 1'b0);
        waitIdle("burst_idle", 2000);
        checkOutput("burst_rsp_count", rspQ.size() - s, 32'd96);
        errs = 0;
        lastErrs = 0;
        for (int i = 0; i < 96 && (s + i) < rspQ.size(); i++) begin
            if (rspQ[s + i].data !== 16'(i)) errs++;
            if (rspQ[s + i].last !== (i == 95)) lastErrs++;
            if (rspQ[s + i].err !== 1'b0) errs++;
        end
        checkOutput("burst_data_errs", errs, 32'd0);
        checkOutput("burst_last_errs", lastErrs, 32'd0);
        errs = 0;
        for (int i = a; i < addrQ.size(); i++) if (addrQ[i] !== SAMPLE_PORT_ADDR) errs++;
        checkOutput("burst_addr_errs", errs, 32'd0);
        checkOutput("burst_xfers", addrQ.size() - a, 32'd96);
        checkOutput("burst_psel_rises", pselRises, 32'd96);

        // Incrementing write burst: silent beats, one final completion
        slaveMode = 0;
        s = rspQ.size();
        a = addrQ.size();
        applyStimulus(1'b1, 21'h0, 16'h00a5, 7'd3, 1'b1);
        waitIdle("wburst_idle", 100);
        checkOutput("wburst_xfers", addrQ.size() - a, 32'd4);
        errs = 0;
        for (int i = 0; i < 4 && (a + i) < addrQ.size(); i++) if (addrQ[a + i] !== 21'(i)) errs++;
        checkOutput("wburst_addr_errs", errs, 32'd0);
        checkOutput("wburst_rsp_count", rspQ.size() - s, 32'd1);
        if (rspQ.size() > s) checkOutput("wburst_rsp", {14'd0, rspQ[s].data, rspQ[s].last, rspQ[s].err}, {14'd0, 16'h0, 1'b1, 1'b0});

        // Timeout: slave never ready
        slaveMode = 2;
        s = rspQ.size();
        applyStimulus(1'b0, 21'h10, 16'h0, 7'd3, 1'b0);
        waitIdle("to_idle", 400);
        checkOutput("to_psel_cycles", lastRun, 32'd255);
        checkOutput("to_rsp_count", rspQ.size() - s, 32'd1);
        if (rspQ.size() > s) checkOutput("to_rsp", {14'd0, rspQ[s].data, rspQ[s].last, rspQ[s].err}, {14'd0, 16'hffff, 1'b1, 1'b1});

        // Recovery after timeout
        slaveMode = 0;
        dataBase  = 16'h1234;
        xferStart = xferCount;
        s = rspQ.size();
        applyStimulus(1'b0, 21'h20, 16'h0, 7'd0, 1'b0);
        waitIdle("rec_idle", 20);
        checkOutput("rec_rsp_count", rspQ.size() - s, 32'd1);
        if (rspQ.size() > s) checkOutput("rec_rsp", {14'd0, rspQ[s].data, rspQ[s].last, rspQ[s].err}, {14'd0, 16'h1234, 1'b1, 1'b0});

        // Response back-pressure for 10 cycles during a 4-beat read
        dataBase  = 16'h0100;
        xferStart = xferCount;
        s = rspQ.size();
        rsp_rdy = 1'b0;
        applyStimulus(1'b0, 21'h40, 16'h0, 7'd3, 1'b1);
        errs = 0;
        @(negedge clk);
        while (!rsp_vld && errs < 20) begin
            @(negedge clk);
            errs++;
        end
        checkOutput("bp_first_vld", {31'd0, rsp_vld}, 32'd1);
        r0 = '{data: rsp_data, last: rsp_last, err: rsp_err};
        checkOutput("bp_first_rsp", {14'd0, r0}, {14'd0, 16'h0100, 1'b0, 1'b0});
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (psel !== 1'b0 || rsp_vld !== 1'b1) errs++;
            if (rsp_data !== r0.data || rsp_last !== r0.last || rsp_err !== r0.err) errs++;
        end
        checkOutput("bp_stable_errs", errs, 32'd0);
        @(posedge clk);
        #1;
        rsp_rdy = 1'b1;
        waitIdle("bp_idle", 50);
        checkOutput("bp_rsp_count", rspQ.size() - s, 32'd4);
        errs = 0;
        for (int i = 0; i < 4 && (s + i) < rspQ.size(); i++) begin
            if (rspQ[s + i].data !== 16'h0100 + 16'(i)) errs++;
            if (rspQ[s + i].last !== (i == 3)) errs++;
        end
        checkOutput("bp_data_errs", errs, 32'd0);

        // Asynchronous reset mid-burst: once during a response, once during psel
        slaveMode = 1;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, SAMPLE_PORT_ADDR, 16'h0, 7'd95, 1'b0);
            errs = 0;
            @(negedge clk);
            while (((k == 0) ? !rsp_vld : !psel) && errs < 50) begin
                @(negedge clk);
                errs++;
            end
            checkOutput("mid_busy", {31'd0, busy}, 32'd1);
            #2;
            rstn = 1'b0;
            #1;
            checkOutput("mid_rst_psel_vld", {30'd0, psel, rsp_vld}, 32'd0);
            checkOutput("mid_rst_busy_rdy", {30'd0, busy, cmd_rdy}, 32'd0);
            checkOutput("mid_rst_paddr", {11'd0, paddr}, 32'd0);
            repeat (2) @(posedge clk);
            @(negedge clk);
            rstn = 1'b1;
            #1;
            checkOutput("mid_rel_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
            s = rspQ.size();
            repeat (10) @(negedge clk);
            checkOutput("mid_no_rsp", rspQ.size() - s, 32'd0);
            checkOutput("mid_psel_idle", {31'd0, psel}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule : tb_adc_apb_master
